// File: rtl/dmem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter_if
//   One requester port of the data-memory arbiter. The MIPS core and the
//   debug/loader port each get one instance.
//   Signals:
//     req     requester -> arbiter  access request, held with its fields until gnt
//     we      requester -> arbiter  1 = write, 0 = read
//     addr    requester -> arbiter  word address (AW bits)
//     wdata   requester -> arbiter  write data (DW bits)
//     gnt     arbiter -> requester  access performed this cycle
//     stall   arbiter -> requester  req & ~gnt
//     rvalid  arbiter -> requester  read data valid, one cycle after a read grant
//     rdata   arbiter -> requester  read data, meaningful only with rvalid
//   Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          stall;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, stall, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, stall, rvalid, rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single-port 128x32 data SRAM between the MIPS core (C port) and
//   a debug/loader port (D port). The core has fixed priority, but a
//   starvation counter forces a D grant once D has lost MAX_WAIT consecutive
//   cycles. Read data comes back one cycle after the grant on the port that
//   issued the read.
//   Ports:
//     clk         clock, all state on posedge
//     rst_n       synchronous active-low reset
//     c_port      CPU requester port (slave modport)
//     d_port      debug/loader requester port (slave modport)
//     o_d_starve  high when the starvation counter is at MAX_WAIT
//     o_mem_cen   SRAM chip enable, active-low
//     o_mem_wen   SRAM write enable, active-low
//     o_mem_oen   SRAM output enable, active-low
//     o_mem_a     SRAM word address
//     o_mem_d     SRAM write data
//     i_mem_q     SRAM read data, valid the cycle after a read strobe
// ----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_port_arbiter_if.slave   c_port,
  dmem_port_arbiter_if.slave   d_port,
  output logic                 o_d_starve,
  output logic                 o_mem_cen,
  output logic                 o_mem_wen,
  output logic                 o_mem_oen,
  output logic [AW-1:0]        o_mem_a,
  output logic [DW-1:0]        o_mem_d,
  input  logic [DW-1:0]        i_mem_q
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  // Which port (if any) owns the SRAM read data arriving next cycle.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_C,
    OWN_D
  } owner_t;

  owner_t     r_rdOwner;
  owner_t     w_rdOwnerNext;
  logic [3:0] r_waitCnt;
  logic       w_force;
  logic       w_cGnt;
  logic       w_dGnt;

  // Grant decision: the core wins unless D has waited long enough to be
  // forced, or the core is not asking. Grants are masked during reset so the
  // SRAM sees no strobes while rst_n is low.
  always_comb begin
    w_force = d_port.req & (r_waitCnt == MaxWait);
    w_dGnt  = rst_n & d_port.req & (w_force | ~c_port.req);
    w_cGnt  = rst_n & c_port.req & ~w_dGnt;
  end

  // SRAM strobes and address/data come from the winner; with no winner the
  // strobes are parked inactive and the buses are driven to zero.
  always_comb begin
    o_mem_cen = 1'b1;
    o_mem_wen = 1'b1;
    o_mem_oen = 1'b1;
    o_mem_a   = '0;
    o_mem_d   = '0;
    if (w_dGnt) begin
      o_mem_cen = 1'b0;
      o_mem_wen = ~d_port.we;
      o_mem_oen = d_port.we;
      o_mem_a   = d_port.addr;
      o_mem_d   = d_port.wdata;
    end else if (w_cGnt) begin
      o_mem_cen = 1'b0;
      o_mem_wen = ~c_port.we;
      o_mem_oen = c_port.we;
      o_mem_a   = c_port.addr;
      o_mem_d   = c_port.wdata;
    end
  end

  // Read-owner state register. Reset drops any read still in flight so no
  // rvalid appears after reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdOwner <= OWN_NONE;
    end else begin
      r_rdOwner <= w_rdOwnerNext;
    end
  end

  // Next read owner: a granted read claims the data returning next cycle.
  // Writes complete at the grant edge and produce no response.
  always_comb begin
    w_rdOwnerNext = OWN_NONE;
    if (w_cGnt && !c_port.we) begin
      w_rdOwnerNext = OWN_C;
    end else if (w_dGnt && !d_port.we) begin
      w_rdOwnerNext = OWN_D;
    end
  end

  // Starvation counter: counts consecutive cycles D asked and lost,
  // saturating at MAX_WAIT. Any D grant or a dropped D request clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_waitCnt <= 4'd0;
    end else if (d_port.req && !w_dGnt) begin
      if (r_waitCnt != MaxWait) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
    end else begin
      r_waitCnt <= 4'd0;
    end
  end

  // rvalid is gated by rst_n so a read granted just before reset asserts
  // never shows up while reset is held.
  assign c_port.gnt    = w_cGnt;
  assign d_port.gnt    = w_dGnt;
  assign c_port.stall  = c_port.req & ~w_cGnt;
  assign d_port.stall  = d_port.req & ~w_dGnt;
  assign c_port.rvalid = rst_n & (r_rdOwner == OWN_C);
  assign d_port.rvalid = rst_n & (r_rdOwner == OWN_D);
  assign c_port.rdata  = i_mem_q;
  assign d_port.rdata  = i_mem_q;
  assign o_d_starve    = (r_waitCnt == MaxWait);

endmodule
